// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor.
// State encoding, counter widths and a saturating increment helper.
package pll_sup_pkg;

  localparam int CNT_W  = 16;
  localparam int STAT_W = 8;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_e;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear to 0 on reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock qualification and release of the
// downstream reset; counts lock losses and lock timeouts.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 64,
  parameter int HOLD_CYCLES    = 256,
  parameter int LOCK_TIMEOUT   = 50000
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              locked,
  input  logic              soft_rst,
  output logic              pll_rst,
  output logic              sys_rst,
  output logic              ready,
  output logic [STAT_W-1:0] lock_lost_cnt,
  output logic [STAT_W-1:0] timeout_cnt
);

  if (PLL_RST_CYCLES < 1 || PLL_RST_CYCLES > 65535 ||
      LOCK_FILTER    < 1 || LOCK_FILTER    > 65535 ||
      HOLD_CYCLES    < 1 || HOLD_CYCLES    > 65535 ||
      LOCK_TIMEOUT   < 1 || LOCK_TIMEOUT   > 65535) begin : g_param_err
    $error("pll_lock_supervisor: parameter out of range 1..65535");
  end

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAT_W-1:0] lost_q, lost_d;
  logic [STAT_W-1:0] tout_q, tout_d;
  logic              locked_s;

  sync_2ff u_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    lost_d  = lost_q;
    tout_d  = tout_q;
    if (soft_rst) begin
      state_d = PLL_RESET;
      // a real lock loss on the same cycle is still counted
      if (state_q == RUN && !locked_s) lost_d = sat_inc(lost_q);
    end else begin
      unique case (state_q)
        PLL_RESET: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = FILTER;
          end else if (cnt_q == TO_LAST) begin
            state_d = PLL_RESET;
            tout_d  = sat_inc(tout_q);
          end
        end
        FILTER: begin
          if (!locked_s)              state_d = WAIT_LOCK;
          else if (cnt_q == FILT_LAST) state_d = HOLD;
        end
        HOLD: begin
          if (!locked_s)              state_d = WAIT_LOCK;
          else if (cnt_q == HOLD_LAST) state_d = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            state_d = PLL_RESET;
            lost_d  = sat_inc(lost_q);
          end
        end
        default: state_d = PLL_RESET;
      endcase
    end
    // soft_rst inside PLL_RESET must also restart the pulse
    cnt_d = (soft_rst || state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= PLL_RESET;
      cnt_q   <= '0;
      lost_q  <= '0;
      tout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      tout_q  <= tout_d;
    end
  end

  assign pll_rst       = (state_q == PLL_RESET);
  assign sys_rst       = (state_q != RUN);
  assign ready         = (state_q == RUN);
  assign lock_lost_cnt = lost_q;
  assign timeout_cnt   = tout_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with short parameters
// (reset 4, filter 8, hold 16, timeout 100).
module tb_pll_lock_supervisor;

  logic       refclk   = 1'b0;
  logic       rst      = 1'b1;
  logic       locked   = 1'b1;
  logic       soft_rst = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_lost_cnt;
  logic [7:0] timeout_cnt;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int    cyc;
    logic  pll;
    logic  sys;
    logic  rdy;
    int    lost;
    int    tout;
  } exp_t;

  exp_t q[$];
  event chk_now;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_FILTER    (8),
    .HOLD_CYCLES    (16),
    .LOCK_TIMEOUT   (100)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .locked        (locked),
    .soft_rst      (soft_rst),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  always #10 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic expect_at(input string name, input int dc,
                           input logic p, input logic s,
                           input logic r, input int l,
                           input int t);
    exp_t e;
    e.name = name;
    e.cyc  = cyc + dc;
    e.pll  = p;
    e.sys  = s;
    e.rdy  = r;
    e.lost = l;
    e.tout = t;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge refclk or chk_now);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if ({pll_rst, sys_rst, ready} !== {e.pll, e.sys, e.rdy} ||
            lock_lost_cnt !== 8'(e.lost) ||
            timeout_cnt !== 8'(e.tout)) begin
          errors++;
          $display("FAIL %s cyc=%0d: got pll=%b sys=%b rdy=%b lost=%0d tout=%0d, required pll=%b sys=%b rdy=%b lost=%0d tout=%0d",
                   e.name, cyc, pll_rst, sys_rst, ready,
                   lock_lost_cnt, timeout_cnt, e.pll, e.sys, e.rdy,
                   e.lost, e.tout);
        end
      end
    end
  end

  initial begin : stim
    wait_cyc(2);
    expect_at("rst_state", 0, 1, 1, 0, 0, 0);
    wait_cyc(1);
    rst = 1'b0;
    expect_at("pwr_pll_hi", 3,  1, 1, 0, 0, 0);
    expect_at("pwr_pll_lo", 4,  0, 1, 0, 0, 0);
    expect_at("pwr_hold",   28, 0, 1, 0, 0, 0);
    expect_at("pwr_run",    29, 0, 0, 1, 0, 0);
    wait_cyc(30);

    expect_at("ll_pre",   2,  0, 0, 1, 0, 0);
    expect_at("ll_sys",   3,  1, 1, 0, 1, 0);
    expect_at("ll_pulse", 6,  1, 1, 0, 1, 0);
    expect_at("ll_wait",  7,  0, 1, 0, 1, 0);
    expect_at("ll_hold",  31, 0, 1, 0, 1, 0);
    expect_at("ll_run",   32, 0, 0, 1, 1, 0);
    locked = 1'b0;
    wait_cyc(1);
    locked = 1'b1;
    wait_cyc(32);

    expect_at("soft_run",   1,  1, 1, 0, 1, 0);
    expect_at("hold_pre",   20, 0, 1, 0, 1, 0);
    expect_at("soft_hold",  21, 1, 1, 0, 1, 0);
    expect_at("soft_rerun", 50, 0, 0, 1, 1, 0);
    soft_rst = 1'b1;
    wait_cyc(1);
    soft_rst = 1'b0;
    wait_cyc(19);
    soft_rst = 1'b1;
    wait_cyc(1);
    soft_rst = 1'b0;
    wait_cyc(30);

    expect_at("both_pre", 2, 0, 0, 1, 1, 0);
    expect_at("both",     3, 1, 1, 0, 2, 0);
    locked = 1'b0;
    wait_cyc(2);
    soft_rst = 1'b1;
    wait_cyc(1);
    soft_rst = 1'b0;

    expect_at("gl_filter", 8,     0, 1, 0, 2, 0);
    expect_at("gl_back",   12,    0, 1, 0, 2, 0);
    expect_at("to1_pre",   111,   0, 1, 0, 2, 0);
    expect_at("to1",       112,   1, 1, 0, 2, 1);
    expect_at("to2",       216,   1, 1, 0, 2, 2);
    expect_at("to3_pre",   319,   0, 1, 0, 2, 2);
    expect_at("to3",       320,   1, 1, 0, 2, 3);
    expect_at("to254",     26527, 0, 1, 0, 2, 254);
    expect_at("to255",     26528, 1, 1, 0, 2, 255);
    expect_at("to256_sat", 26632, 1, 1, 0, 2, 255);
    expect_at("to300_sat", 31208, 1, 1, 0, 2, 255);
    wait_cyc(4);
    locked = 1'b1;
    wait_cyc(5);
    locked = 1'b0;
    wait_cyc(31199);

    expect_at("hold_pre2", 19, 0, 1, 0, 2, 255);
    locked = 1'b1;
    wait_cyc(20);
    #5;
    rst = 1'b1;
    #1;
    expect_at("async_rst", 0, 1, 1, 0, 0, 0);
    -> chk_now;
    wait_cyc(2);
    rst = 1'b0;
    expect_at("rr_pll_hi", 3,  1, 1, 0, 0, 0);
    expect_at("rr_pll_lo", 4,  0, 1, 0, 0, 0);
    expect_at("rr_run",    29, 0, 0, 1, 0, 0);
    wait_cyc(31);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d pending, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
